frag_depth_test: RTL and testbench
==================================

# frag_depth_test

Per-fragment depth-test and framebuffer write stage placed directly downstream of the rasterizer. It consumes the rasterizer's fragment write stream (address, write enable, depth, color), holds the on-chip depth buffer, and forwards only fragments nearer than the stored depth to the framebuffer write port. It also owns the per-frame depth/colour clear sweep, and re-times the rasterizer's `finished` flag to the end of its pipeline.

## Interface
Parameters:
- `DATAWIDTH`, 12: depth word width (unsigned).
- `COLORWIDTH`, 4: colour word width.
- `SCREEN_WIDTH`, 320: pixels per line.
- `SCREEN_HEIGHT`, 320: lines per frame.
- `ADDRWIDTH`, $clog2(SCREEN_WIDTH*SCREEN_HEIGHT): pixel address width.
- `CLEAR_COLOR`, 0: colour written during clear.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `i_frag_addr`, in, ADDRWIDTH: pixel address of the fragment.
- `i_frag_dv`, in, 1: fragment valid, one fragment per cycle, no backpressure.
- `i_frag_depth`, in, DATAWIDTH: fragment depth, smaller is nearer.
- `i_frag_color`, in, COLORWIDTH: fragment colour.
- `i_finished`, in, 1: rasterizer finished pulse.
- `i_clear`, in, 1: clear request pulse.
- `ready`, out, 1: high when fragments may be presented.
- `o_fb_addr_write`, out, ADDRWIDTH: framebuffer write address.
- `o_fb_write_en`, out, 1: framebuffer write strobe.
- `o_fb_color_data`, out, COLORWIDTH: framebuffer write colour.
- `o_clear_done`, out, 1: one-cycle pulse when the clear completes.
- `o_finished`, out, 1: `i_finished` delayed to pipeline exit.

## Operation
- Depth memory: SCREEN_WIDTH*SCREEN_HEIGHT words × DATAWIDTH, synchronous read, read-during-write returns old data.
- FSM states:
  - READY: fragments accepted.
  - DRAIN: clear pending, pipeline emptying.
  - CLEAR: sweep in progress.
- Transitions:
  - READY→DRAIN on `i_clear`.
  - DRAIN→CLEAR when both pipeline stages are empty.
  - CLEAR→READY after writing the last address.
- Pipeline:
  - S0: accept the fragment and issue the depth read.
  - S1: compare. Pass iff `i_frag_depth` < stored depth, strictly less, unsigned. A pass writes the depth memory and registers the framebuffer write.
- Forwarding: if the S1 fragment's address equals the address written by the previous cycle's passing fragment, compare against that forwarded depth, not the memory output.
- Failing fragments produce no `o_fb_write_en` and no depth write.
- CLEAR sweep:
  - Address counter runs 0..SCREEN_WIDTH*SCREEN_HEIGHT-1, one per cycle.
  - Each cycle writes all-ones depth and drives `o_fb_write_en`=1 with `CLEAR_COLOR`.
  - `o_clear_done` pulses in the cycle after the last write.
- `ready` is 1 only in READY. Fragments with `i_frag_dv` while `ready`=0 are discarded.
- `i_clear` in DRAIN or CLEAR is ignored.
- `i_clear` together with `i_frag_dv` in READY: the fragment is accepted, then the clear proceeds via DRAIN.
- `i_finished` is carried through a 2-stage shift, aligned with the last fragment's write.

## Timing
- Reset values: `ready`=0 during reset, 1 in the first cycle after release (FSM in READY). All other outputs are 0.
- Depth memory contents are undefined after reset; a clear is required before the first frame.
- Fragment latency: fragment sampled at edge N; `o_fb_write_en`/addr/colour valid in the cycle after edge N+2. The depth write is committed on the same edge.
- Throughput: one fragment per cycle, back-to-back, including repeated identical addresses.
- Clear: `i_clear` sampled in READY with an empty pipeline gives DRAIN for 2 cycles, then CLEAR for SCREEN_WIDTH*SCREEN_HEIGHT cycles, then the `o_clear_done` pulse. `ready` returns to 1 in the same cycle as `o_clear_done`.
- Reset mid-clear or mid-pipeline aborts immediately: FSM to READY, in-flight fragments dropped, no partial outputs.

## Configuration
- `FRAG_DEPTH_TEST_STATS_EN`, when defined, adds two 32-bit outputs:
  - `o_pass_count` and `o_fail_count`, incremented per S1 result.
  - Both cleared by reset and at entry to CLEAR, saturating at all-ones.
- When undefined, these ports and their counters do not exist. Depth-test behaviour is identical in both builds.

## Test plan
- Reset, then `i_clear` → `ready` low; 102400 consecutive writes with addresses 0..102399 and colour 0; `o_clear_done` pulses once; `ready`=1 in the same cycle.
- After clear, fragment addr 5, depth 100, colour 3 → one write, addr 5, colour 3, exactly 2 cycles after input. A later fragment addr 5, depth 100 → no write (equal fails).
- Back-to-back addr 7: depth 50 then depth 60 → only the first writes. Then depth 40 then depth 45 → only the depth 40 fragment writes (forwarding verified).
- `i_clear` asserted together with a valid fragment → the fragment writes first, then DRAIN, then the sweep. A fragment presented during CLEAR → discarded, no extra write.
- `rst` pulsed at clear address 1000 → no further writes; `ready`=1 after release; `o_clear_done` never pulses.
- With `FRAG_DEPTH_TEST_STATS_EN`: 3 passing and 2 failing fragments → `o_pass_count`=3, `o_fail_count`=2; both read 0 after the next clear starts.

Source files
------------

// File: rtl/frag_depth_test.sv
// frag_depth_test: depth test and framebuffer write stage with clear sweep; FRAG_DEPTH_TEST_STATS_EN adds pass/fail counters
module frag_depth_test #(
  parameter int DATAWIDTH = 12,
  parameter int COLORWIDTH = 4,
  parameter int SCREEN_WIDTH = 320,
  parameter int SCREEN_HEIGHT = 320,
  parameter int ADDRWIDTH = $clog2(SCREEN_WIDTH*SCREEN_HEIGHT),
  parameter logic [COLORWIDTH-1:0] CLEAR_COLOR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDRWIDTH-1:0]  i_frag_addr,
  input  logic                  i_frag_dv,
  input  logic [DATAWIDTH-1:0]  i_frag_depth,
  input  logic [COLORWIDTH-1:0] i_frag_color,
  input  logic                  i_finished,
  input  logic                  i_clear,
  output logic                  ready,
  output logic [ADDRWIDTH-1:0]  o_fb_addr_write,
  output logic                  o_fb_write_en,
  output logic [COLORWIDTH-1:0] o_fb_color_data,
  output logic                  o_clear_done,
  output logic                  o_finished
`ifdef FRAG_DEPTH_TEST_STATS_EN
  ,
  output logic [31:0]           o_pass_count,
  output logic [31:0]           o_fail_count
`endif
);
  localparam int NPIX = SCREEN_WIDTH*SCREEN_HEIGHT;
  localparam logic [ADDRWIDTH-1:0] LAST = ADDRWIDTH'(NPIX-1);
  typedef enum logic [1:0] {READY, DRAIN, CLEAR} state_t;
  state_t state_q, state_d;
  logic drain_first_q;
  logic [ADDRWIDTH-1:0] clr_q;
  logic done_q;
  logic s0_v_q, s1_v_q, we_q;
  logic [ADDRWIDTH-1:0] s0_addr_q, s1_addr_q, addr_q;
  logic [DATAWIDTH-1:0] s0_depth_q, s1_depth_q, wdepth_q, rd_q;
  logic [COLORWIDTH-1:0] s0_color_q, s1_color_q, color_q;
  logic [1:0] fin_q;
  logic [DATAWIDTH-1:0] mem [NPIX];
  logic accept, clearing, pass;
  logic [DATAWIDTH-1:0] stored;
  assign accept = i_frag_dv && state_q == READY;
  assign clearing = state_q == CLEAR;
  // the previous pass is committed on the same edge as our read, so the memory still shows the old depth
  assign stored = (we_q && addr_q == s1_addr_q) ? wdepth_q : rd_q;
  assign pass = s1_v_q && s1_depth_q < stored;
  assign ready = state_q == READY && !rst;
  assign o_fb_write_en = clearing || we_q;
  assign o_fb_addr_write = clearing ? clr_q : addr_q;
  assign o_fb_color_data = clearing ? CLEAR_COLOR : color_q;
  assign o_clear_done = done_q;
  assign o_finished = fin_q[1];
  // next state: DRAIN holds at least two cycles and until S0, S1 and the output register are empty
  always_comb begin
    state_d = state_q;
    case (state_q)
      READY: state_d = i_clear ? DRAIN : READY;
      DRAIN: state_d = (!drain_first_q && !s0_v_q && !s1_v_q && !we_q) ? CLEAR : DRAIN;
      CLEAR: state_d = clr_q == LAST ? READY : CLEAR;
      default: state_d = READY;
    endcase
  end
  // control, pipeline stages and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= READY;
      drain_first_q <= 1'b0;
      clr_q <= '0;
      done_q <= 1'b0;
      s0_v_q <= 1'b0;
      s0_addr_q <= '0;
      s0_depth_q <= '0;
      s0_color_q <= '0;
      s1_v_q <= 1'b0;
      s1_addr_q <= '0;
      s1_depth_q <= '0;
      s1_color_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdepth_q <= '0;
      color_q <= '0;
      fin_q <= '0;
    end else begin
      state_q <= state_d;
      drain_first_q <= state_q == READY && i_clear;
      clr_q <= clearing ? clr_q + 1'b1 : '0;
      done_q <= clearing && clr_q == LAST;
      s0_v_q <= accept;
      s0_addr_q <= i_frag_addr;
      s0_depth_q <= i_frag_depth;
      s0_color_q <= i_frag_color;
      s1_v_q <= s0_v_q;
      s1_addr_q <= s0_addr_q;
      s1_depth_q <= s0_depth_q;
      s1_color_q <= s0_color_q;
      we_q <= pass;
      addr_q <= s1_addr_q;
      wdepth_q <= s1_depth_q;
      color_q <= s1_color_q;
      fin_q <= {fin_q[0], i_finished};
    end
  end
  // depth memory: sweep or passing fragment writes, synchronous read returning old data
  always_ff @(posedge clk) begin
    if (clearing)
      mem[clr_q] <= '1;
    else if (pass)
      mem[s1_addr_q] <= s1_depth_q;
    rd_q <= mem[s0_addr_q];
  end
`ifdef FRAG_DEPTH_TEST_STATS_EN
  logic [31:0] pass_cnt_q, fail_cnt_q;
  assign o_pass_count = pass_cnt_q;
  assign o_fail_count = fail_cnt_q;
  // saturating per-result counters, zeroed as the sweep begins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else if (state_q == DRAIN && state_d == CLEAR) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      if (pass && !(&pass_cnt_q))
        pass_cnt_q <= pass_cnt_q + 1;
      if (s1_v_q && !pass && !(&fail_cnt_q))
        fail_cnt_q <= fail_cnt_q + 1;
    end
  end
`endif
endmodule

// File: tb/tb_frag_depth_test.sv
// tb_frag_depth_test: directed checks of depth test, forwarding, clear sweep and reset abort on a 16x8 screen
module tb_frag_depth_test;
  localparam int AW = 7;
  localparam int NP = 128;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [AW-1:0] i_frag_addr = '0;
  logic i_frag_dv = 1'b0;
  logic [11:0] i_frag_depth = '0;
  logic [3:0] i_frag_color = '0;
  logic i_finished = 1'b0;
  logic i_clear = 1'b0;
  logic ready, o_fb_write_en, o_clear_done, o_finished;
  logic [AW-1:0] o_fb_addr_write;
  logic [3:0] o_fb_color_data;
`ifdef FRAG_DEPTH_TEST_STATS_EN
  logic [31:0] o_pass_count, o_fail_count;
`endif
  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int w, d;
  always #5 clk = ~clk;
  frag_depth_test #(.SCREEN_WIDTH(16), .SCREEN_HEIGHT(8)) dut (
    .clk(clk), .rst(rst),
    .i_frag_addr(i_frag_addr), .i_frag_dv(i_frag_dv), .i_frag_depth(i_frag_depth),
    .i_frag_color(i_frag_color), .i_finished(i_finished), .i_clear(i_clear),
    .ready(ready), .o_fb_addr_write(o_fb_addr_write), .o_fb_write_en(o_fb_write_en),
    .o_fb_color_data(o_fb_color_data), .o_clear_done(o_clear_done), .o_finished(o_finished)
`ifdef FRAG_DEPTH_TEST_STATS_EN
    , .o_pass_count(o_pass_count), .o_fail_count(o_fail_count)
`endif
  );
  always @(negedge clk) begin
    if (o_fb_write_en) wr_cnt++;
    if (o_clear_done) done_cnt++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [AW-1:0] a, input logic [11:0] dp, input logic [3:0] c, input logic clr);
    i_frag_addr = a;
    i_frag_depth = dp;
    i_frag_color = c;
    i_frag_dv = 1'b1;
    i_clear = clr;
    tick();
    i_frag_dv = 1'b0;
    i_clear = 1'b0;
  endtask
  task automatic sweep(input int frag_from, input int frag_to);
    int bad = 0;
    for (int k = 0; k < NP; k++) begin
      if (!o_fb_write_en || o_fb_addr_write != AW'(k) || o_fb_color_data != 4'd0 || ready || o_clear_done) bad++;
      i_frag_dv = k >= frag_from && k < frag_to;
      i_frag_addr = AW'(3);
      i_frag_depth = 12'd0;
      i_frag_color = 4'hf;
      i_clear = k == frag_from;
      tick();
    end
    i_frag_dv = 1'b0;
    i_clear = 1'b0;
    check("sweep_seq", bad, 0);
    check("clear_done", o_clear_done, 1);
    check("ready_at_done", ready, 1);
    check("we_at_done", o_fb_write_en, 0);
    tick();
    check("done_one_cycle", o_clear_done, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tick();
    tick();
    check("rst_ready", ready, 0);
    check("rst_we", o_fb_write_en, 0);
    check("rst_done", o_clear_done, 0);
    check("rst_fin", o_finished, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", ready, 1);
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    check("drain1_ready", ready, 0);
    check("drain1_we", o_fb_write_en, 0);
    tick();
    check("drain2_ready", ready, 0);
    check("drain2_we", o_fb_write_en, 0);
    tick();
    sweep(NP, NP);
    send(AW'(5), 12'd100, 4'd3, 1'b0);
    check("lat_n_we", o_fb_write_en, 0);
    tick();
    check("lat_n1_we", o_fb_write_en, 0);
    tick();
    check("lat_we", o_fb_write_en, 1);
    check("lat_addr", o_fb_addr_write, 5);
    check("lat_col", o_fb_color_data, 3);
    tick();
    check("lat_single", o_fb_write_en, 0);
    w = wr_cnt;
    send(AW'(5), 12'd100, 4'd7, 1'b0);
    repeat (4) tick();
    check("equal_fails", wr_cnt - w, 0);
    w = wr_cnt;
    send(AW'(7), 12'd50, 4'd1, 1'b0);
    send(AW'(7), 12'd60, 4'd2, 1'b0);
    tick();
    check("b2b_first_we", o_fb_write_en, 1);
    check("b2b_first_col", o_fb_color_data, 1);
    tick();
    check("fwd_60_fails", o_fb_write_en, 0);
    tick();
    tick();
    check("fwd_60_cnt", wr_cnt - w, 1);
    w = wr_cnt;
    send(AW'(7), 12'd40, 4'd4, 1'b0);
    send(AW'(7), 12'd45, 4'd5, 1'b0);
    tick();
    check("fwd_40_we", o_fb_write_en, 1);
    check("fwd_40_col", o_fb_color_data, 4);
    tick();
    check("fwd_45_fails", o_fb_write_en, 0);
    tick();
    tick();
    check("fwd_45_cnt", wr_cnt - w, 1);
    send(AW'(8), 12'd10, 4'd6, 1'b0);
    send(AW'(9), 12'd10, 4'd7, 1'b0);
    tick();
    check("tp_a_addr", o_fb_addr_write, 8);
    check("tp_a_we", o_fb_write_en, 1);
    tick();
    check("tp_b_addr", o_fb_addr_write, 9);
    check("tp_b_col", o_fb_color_data, 7);
    check("tp_b_we", o_fb_write_en, 1);
    tick();
    i_finished = 1'b1;
    tick();
    i_finished = 1'b0;
    check("fin_d1", o_finished, 0);
    tick();
    check("fin_d2", o_finished, 1);
    tick();
    check("fin_end", o_finished, 0);
    send(AW'(20), 12'd5, 4'd9, 1'b1);
    check("clrfrag_ready", ready, 0);
    tick();
    tick();
    check("clrfrag_we", o_fb_write_en, 1);
    check("clrfrag_addr", o_fb_addr_write, 20);
    check("clrfrag_col", o_fb_color_data, 9);
    tick();
    check("clrfrag_gap_we", o_fb_write_en, 0);
    check("clrfrag_gap_ready", ready, 0);
    tick();
    sweep(10, 20);
    w = wr_cnt;
    repeat (6) tick();
    check("discard_in_clear", wr_cnt - w, 0);
`ifdef FRAG_DEPTH_TEST_STATS_EN
    check("stats_pass0", o_pass_count, 0);
    check("stats_fail0", o_fail_count, 0);
    send(AW'(30), 12'd1, 4'd1, 1'b0);
    send(AW'(31), 12'd1, 4'd1, 1'b0);
    send(AW'(32), 12'd1, 4'd1, 1'b0);
    repeat (3) tick();
    send(AW'(30), 12'd1, 4'd2, 1'b0);
    repeat (3) tick();
    send(AW'(31), 12'd2, 4'd2, 1'b0);
    repeat (3) tick();
    check("stats_pass3", o_pass_count, 3);
    check("stats_fail2", o_fail_count, 2);
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    tick();
    tick();
    check("stats_clr_pass", o_pass_count, 0);
    check("stats_clr_fail", o_fail_count, 0);
    sweep(NP, NP);
`endif
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    tick();
    tick();
    repeat (100) tick();
    check("abort_pre_we", o_fb_write_en, 1);
    check("abort_pre_addr", o_fb_addr_write, 100);
    rst = 1'b1;
    #1;
    check("abort_we", o_fb_write_en, 0);
    check("abort_ready", ready, 0);
    tick();
    rst = 1'b0;
    #1;
    check("abort_ready_after", ready, 1);
    w = wr_cnt;
    d = done_cnt;
    repeat (200) tick();
    check("abort_no_writes", wr_cnt - w, 0);
    check("abort_no_done", done_cnt - d, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
